// File: rtl/idac_arb_ctrl_if.sv
// -----------------------------------------------------------------------------
// idac_arb_ctrl_if
// Request/iDAC bundle between two requesters, the arbiter and the iDAC.
//   en_i           : controller enable
//   req_i[1:0]     : per-requester request (bit 0 software, bit 1 stimulus)
//   current_i      : packed per-requester current codes, requester k at
//                    [k*CurrentWidth +: CurrentWidth]
//   calib_i        : packed per-requester calibration codes, same packing
//   ack_o[1:0]     : one-cycle completion pulse to the granted requester
//   idac_current_o : current code to the iDAC
//   idac_calib_o   : calibration code to the iDAC
//   idac_trigger_o : one-cycle iDAC update strobe
//   busy_o         : controller not idle
//   clamped_o      : launched current code was clamped (with trigger)
// -----------------------------------------------------------------------------
interface idac_arb_ctrl_if #(
    parameter int unsigned CurrentWidth = 8,
    parameter int unsigned CalibWidth   = 5
);
    logic                      en_i;
    logic [1:0]                req_i;
    logic [2*CurrentWidth-1:0] current_i;
    logic [2*CalibWidth-1:0]   calib_i;
    logic [1:0]                ack_o;
    logic [CurrentWidth-1:0]   idac_current_o;
    logic [CalibWidth-1:0]     idac_calib_o;
    logic                      idac_trigger_o;
    logic                      busy_o;
    logic                      clamped_o;

    // Requester/environment side
    modport master (
        output en_i, req_i, current_i, calib_i,
        input  ack_o, idac_current_o, idac_calib_o, idac_trigger_o, busy_o, clamped_o
    );

    // Controller side
    modport slave (
        input  en_i, req_i, current_i, calib_i,
        output ack_o, idac_current_o, idac_calib_o, idac_trigger_o, busy_o, clamped_o
    );
endinterface

// File: rtl/idac_arb_ctrl.sv
// -----------------------------------------------------------------------------
// idac_arb_ctrl
// Round-robin arbiter between two requesters sharing one iDAC. A grant latches
// the winner's (clamped) current and calibration codes, strobes the iDAC, waits
// the data-ready delay and acknowledges the winner. With the controller
// disabled and a non-zero current applied, the iDAC is driven back to zero.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : idac_arb_ctrl_if.slave (requests, codes, acks, iDAC drive, status)
// -----------------------------------------------------------------------------
module idac_arb_ctrl #(
    parameter int unsigned CurrentWidth   = 8,
    parameter int unsigned CalibWidth     = 5,
    parameter int unsigned Trig2DrDelayCc = 3,
    parameter int unsigned MaxCurrent     = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    idac_arb_ctrl_if.slave bus
);
    localparam int unsigned CntWidth = 4;
    // Last WAIT count before ACK (WAIT spans Trig2DrDelayCc-1 cycles)
    localparam logic [CntWidth-1:0] WaitLast =
        CntWidth'((Trig2DrDelayCc > 1) ? (Trig2DrDelayCc - 2) : 0);
    // Last SHUT count before IDLE (SHUT spans Trig2DrDelayCc cycles)
    localparam logic [CntWidth-1:0] ShutLast = CntWidth'(Trig2DrDelayCc - 1);
    localparam logic [CurrentWidth-1:0] MaxCode = CurrentWidth'(MaxCurrent);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, ACK, SHUT} state_e;

    state_e                  state_q;
    logic [CntWidth-1:0]     cnt_q;
    logic                    last_q;     // last granted requester, also ack target
    logic [1:0]              ack_q;
    logic [CurrentWidth-1:0] cur_q;
    logic [CalibWidth-1:0]   cal_q;
    logic                    trig_q;
    logic                    busy_q;
    logic                    clamp_q;

    logic                    win_c;
    logic [CurrentWidth-1:0] cur_raw_c;
    logic [CalibWidth-1:0]   cal_raw_c;

    // Round-robin pick: lone requester wins, a tie goes to the one not granted last
    always_comb begin
        win_c = 1'b0;
        if (bus.req_i == 2'b10) begin
            win_c = 1'b1;
        end else if (bus.req_i == 2'b11) begin
            win_c = ~last_q;
        end
        cur_raw_c = win_c ? bus.current_i[CurrentWidth +: CurrentWidth]
                          : bus.current_i[0 +: CurrentWidth];
        cal_raw_c = win_c ? bus.calib_i[CalibWidth +: CalibWidth]
                          : bus.calib_i[0 +: CalibWidth];
    end

    // Controller FSM; pulse outputs default low every cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            ack_q   <= '0;
            cur_q   <= '0;
            cal_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            ack_q   <= '0;
            trig_q  <= 1'b0;
            clamp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en_i && (bus.req_i != 2'b00)) begin
                        last_q  <= win_c;
                        cur_q   <= (cur_raw_c > MaxCode) ? MaxCode : cur_raw_c;
                        cal_q   <= cal_raw_c;
                        clamp_q <= (cur_raw_c > MaxCode);
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= TRIG;
                    end else if (!bus.en_i && (cur_q != '0)) begin
                        cur_q   <= '0;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SHUT;
                    end
                end
                TRIG: begin
                    cnt_q <= '0;
                    // A one-cycle delay skips WAIT entirely
                    if (Trig2DrDelayCc <= 1) begin
                        ack_q[last_q] <= 1'b1;
                        state_q       <= ACK;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == WaitLast) begin
                        ack_q[last_q] <= 1'b1;
                        state_q       <= ACK;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                SHUT: begin
                    if (cnt_q == ShutLast) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o          = ack_q;
    assign bus.idac_current_o = cur_q;
    assign bus.idac_calib_o   = cal_q;
    assign bus.idac_trigger_o = trig_q;
    assign bus.busy_o         = busy_q;
    assign bus.clamped_o      = clamp_q;

endmodule
